// File: rtl/spi_mem_pkg.sv
// Shared opcodes, status-register layout and FSM states for the SPI memory responder.
package spi_mem_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int STATUS_WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_WEL_BIT] = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave exposing a small byte memory with READ/WRITE/WREN/WRDI/RDSR opcodes.
// All SPI inputs are oversampled on CLKA; MISO is launched from CLKA after each SCLK fall.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_BYTES   = 1,
  parameter int PATTERN_MODE = 0
) (
  input  logic CLKA,
  input  logic rst_n,
  input  logic SPI_CLK,
  input  logic SPI_CS_n,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic busy,
  output logic cmd_err
);

  localparam int AW = $clog2(DEPTH);

  logic w_sclk_sync;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_sync;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;
  logic w_mosi_rise;
  logic w_mosi_fall;
  logic w_unused_sync;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk    (CLKA),
    .rst_n  (rst_n),
    .i_async(SPI_CLK),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk    (CLKA),
    .rst_n  (rst_n),
    .i_async(SPI_CS_n),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk    (CLKA),
    .rst_n  (rst_n),
    .i_async(SPI_MOSI),
    .o_sync (w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  assign w_unused_sync = w_sclk_sync ^ w_mosi_rise ^ w_mosi_fall;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [1:0]    r_byte_cnt;
  logic [6:0]    r_shift;
  logic [7:0]    r_tx;
  logic [AW-1:0] r_addr;
  logic          r_wel;
  logic          r_wrote;
  logic          r_is_read;
  logic          r_rdsr;
  logic          r_wr_pend;
  logic [7:0]    r_wr_data;
  logic          r_miso;
  logic          r_cmd_err;
  logic [1:0]    r_settle;
  logic [7:0]    r_mem [DEPTH];

  logic [7:0]    w_rx_byte;
  logic [AW-1:0] w_addr_next;
  logic [AW-1:0] w_addr_inc;

  assign w_rx_byte   = {r_shift, w_mosi};
  assign w_addr_next = AW'({r_addr, w_mosi});
  assign w_addr_inc  = r_addr + AW'(1);

  // A CS_n already low when reset releases must not look like a new transaction,
  // so falls are only accepted once the synchronisers have flushed.
  always_ff @(posedge CLKA or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 7'd0;
      r_tx       <= 8'd0;
      r_addr     <= '0;
      r_wel      <= 1'b0;
      r_wrote    <= 1'b0;
      r_is_read  <= 1'b0;
      r_rdsr     <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_data  <= 8'd0;
      r_miso     <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_settle   <= 2'd0;
    end else begin
      r_cmd_err <= 1'b0;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;

      if (r_wr_pend) begin
        r_wr_pend <= 1'b0;
        r_addr    <= w_addr_inc;
        r_wrote   <= 1'b1;
      end

      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        if (PATTERN_MODE == 0) r_miso <= 1'b0;
        if (r_wrote || r_wr_pend) r_wel <= 1'b0;
        r_wrote <= 1'b0;
      end else if (w_cs_fall) begin
        if (r_settle == 2'd3) begin
          r_state    <= ST_CMD;
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= 2'd0;
          r_wrote    <= 1'b0;
          if (PATTERN_MODE == 0) r_miso <= 1'b0;
        end
      end else begin
        if (PATTERN_MODE != 0 && w_sclk_fall && !w_cs_sync) r_miso <= ~r_miso;

        case (r_state)
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift   <= w_rx_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= 2'd0;
                case (w_rx_byte)
                  OP_READ: begin
                    r_is_read <= 1'b1;
                    r_rdsr    <= 1'b0;
                    r_state   <= ST_ADDR;
                  end
                  OP_WRITE: begin
                    if (r_wel) begin
                      r_is_read <= 1'b0;
                      r_state   <= ST_ADDR;
                    end else begin
                      r_state   <= ST_IGNORE;
                      r_cmd_err <= 1'b1;
                    end
                  end
                  OP_WREN: begin
                    r_wel   <= 1'b1;
                    r_state <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    r_wel   <= 1'b0;
                    r_state <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    r_rdsr  <= 1'b1;
                    r_tx    <= status_byte(r_wel);
                    r_state <= ST_RD;
                  end
                  default: begin
                    r_state   <= ST_IGNORE;
                    r_cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end

          ST_ADDR: begin
            if (w_sclk_rise) begin
              r_addr    <= w_addr_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'(ADDR_BYTES - 1)) begin
                  if (r_is_read) begin
                    r_tx    <= r_mem[w_addr_next];
                    r_state <= ST_RD;
                  end else begin
                    r_state <= ST_WR;
                  end
                end
              end
            end
          end

          ST_RD: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_rdsr) begin
                  r_tx <= status_byte(r_wel);
                end else begin
                  r_addr <= w_addr_inc;
                  r_tx   <= r_mem[w_addr_inc];
                end
              end
            end else if (w_sclk_fall && PATTERN_MODE == 0) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
          end

          ST_WR: begin
            if (w_sclk_rise) begin
              r_shift   <= w_rx_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_wr_pend <= 1'b1;
                r_wr_data <= w_rx_byte;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  // Memory comes out of reset holding its own address in every byte.
  always_ff @(posedge CLKA or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'(i);
    end else if (r_wr_pend) begin
      r_mem[r_addr] <= r_wr_data;
    end
  end

  assign SPI_MISO = r_miso;
  assign busy     = ~w_cs_sync;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomised and directed SPI transactions against a transaction-level memory model,
// with a memory-backed instance and a pattern-mode instance sharing the same bus.
`timescale 1ns/1ps
module tb_spi_mem_responder;
  import spi_mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int HALF  = 50;

  logic CLKA = 1'b0;
  logic rst_n = 1'b0;
  logic SPI_CLK = 1'b0;
  logic SPI_CS_n = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic miso, busy, cmd_err;
  logic miso_p, busy_p, cmd_err_p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLKA = ~CLKA;

  spi_mem_responder #(.DEPTH(DEPTH), .ADDR_BYTES(1), .PATTERN_MODE(0)) dut (
    .CLKA(CLKA), .rst_n(rst_n), .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(miso), .busy(busy), .cmd_err(cmd_err)
  );

  spi_mem_responder #(.DEPTH(DEPTH), .ADDR_BYTES(1), .PATTERN_MODE(1)) dut_p (
    .CLKA(CLKA), .rst_n(rst_n), .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(miso_p), .busy(busy_p), .cmd_err(cmd_err_p)
  );

  // Transaction-level model
  logic [7:0] m_mem [DEPTH];
  logic       m_wel;
  logic       exp_pat;
  logic       exp_miso;
  bit         exp_valid;
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         err_cnt = 0;
  int         err_cnt_p = 0;
  int         pat_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLKA) begin
    if (cmd_err === 1'b1) err_cnt++;
    if (cmd_err_p === 1'b1) err_cnt_p++;
  end

  always @(miso_p) pat_edges++;

  // Master samples MISO on SCLK rise; every meaningful bit is compared here.
  always @(posedge SPI_CLK) begin
    if (exp_valid) begin
      check("miso_bit", {31'd0, miso}, {31'd0, exp_miso});
      check("miso_pattern", {31'd0, miso_p}, {31'd0, exp_pat});
      check("busy", {31'd0, busy}, 32'd1);
      check("busy_pattern", {31'd0, busy_p}, 32'd1);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i);
    m_wel   = 1'b0;
    exp_pat = 1'b0;
  endtask

  task automatic model_xfer(input int last_bits, output int exp_err);
    int n_full;
    int a;
    bit wrote;
    logic [7:0] st;
    n_full = (last_bits == 8) ? tx_q.size() : tx_q.size() - 1;
    wrote = 0;
    exp_err = 0;
    exp_q.delete();
    foreach (tx_q[i]) exp_q.push_back(8'h00);
    a = (tx_q.size() > 1) ? (int'(tx_q[1]) % DEPTH) : 0;
    if (n_full >= 1) begin
      case (tx_q[0])
        8'h03: for (int k = 2; k < tx_q.size(); k++) exp_q[k] = m_mem[(a + k - 2) % DEPTH];
        8'h02: begin
          if (m_wel) begin
            for (int k = 2; k < n_full; k++) begin
              m_mem[(a + k - 2) % DEPTH] = tx_q[k];
              wrote = 1;
            end
          end else begin
            exp_err = 1;
          end
        end
        8'h06: m_wel = 1'b1;
        8'h04: m_wel = 1'b0;
        8'h05: begin
          st = 8'h00;
          st[1] = m_wel;
          for (int k = 1; k < tx_q.size(); k++) exp_q[k] = st;
        end
        default: exp_err = 1;
      endcase
      if (wrote) m_wel = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int last_bits);
    int exp_err;
    int e0;
    int e1;
    int nb;
    logic [7:0] r;
    model_xfer(last_bits, exp_err);
    e0 = err_cnt;
    e1 = err_cnt_p;
    rx_q.delete();
    SPI_CS_n = 1'b0;
    #(HALF);
    foreach (tx_q[k]) begin
      nb = (k == tx_q.size() - 1) ? last_bits : 8;
      r = 8'h00;
      for (int b = 0; b < nb; b++) begin
        SPI_MOSI  = tx_q[k][7-b];
        exp_miso  = exp_q[k][7-b];
        exp_valid = 1'b1;
        #(HALF);
        SPI_CLK = 1'b1;
        #1 r = {r[6:0], miso};
        #(HALF - 1);
        SPI_CLK = 1'b0;
        exp_pat = ~exp_pat;
      end
      rx_q.push_back(r);
    end
    exp_valid = 1'b0;
    #(HALF);
    SPI_CS_n = 1'b1;
    SPI_MOSI = 1'b0;
    #(2 * HALF);
    check("cmd_err_pulses", 32'(err_cnt - e0), 32'(exp_err));
    check("cmd_err_pulses_pattern", 32'(err_cnt_p - e1), 32'(exp_err));
    $display("[TB] xfer op=0x%02h bytes=%0d last_bits=%0d exp_err=%0d", tx_q[0], tx_q.size(), last_bits, exp_err);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int p0;
    int len;
    int lb;
    int sel;
    logic [7:0] op;
    logic [7:0] v;

    exp_valid = 1'b0;
    exp_miso  = 1'b0;
    model_reset();

    repeat (4) @(posedge CLKA);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("reset_miso_pattern", {31'd0, miso_p}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge CLKA);

    // Plain read from reset contents
    tx_q = {8'h03, 8'h05, 8'h00, 8'h00, 8'h00};
    spi_xfer(8);
    check("read05_b0", 32'(rx_q[2]), 32'h05);
    check("read05_b1", 32'(rx_q[3]), 32'h06);
    check("read05_b2", 32'(rx_q[4]), 32'h07);

    // Write across the top of memory, then read back and confirm wrap
    tx_q = {8'h06};
    spi_xfer(8);
    tx_q = {8'h02, 8'h0E, 8'hAA, 8'hBB, 8'hCC};
    spi_xfer(8);
    tx_q = {8'h03, 8'h0E, 8'h00, 8'h00, 8'h00};
    spi_xfer(8);
    check("wrap_b0", 32'(rx_q[2]), 32'hAA);
    check("wrap_b1", 32'(rx_q[3]), 32'hBB);
    check("wrap_b2", 32'(rx_q[4]), 32'hCC);
    tx_q = {8'h03, 8'h00, 8'h00};
    spi_xfer(8);
    check("wrap_addr0", 32'(rx_q[2]), 32'hCC);
    tx_q = {8'h05, 8'h00};
    spi_xfer(8);
    check("rdsr_after_write", 32'(rx_q[1]), 32'h00);

    // Write without WREN is rejected
    e0 = err_cnt;
    tx_q = {8'h02, 8'h03, 8'h55};
    spi_xfer(8);
    check("wr_no_wel_err", 32'(err_cnt - e0), 32'd1);
    tx_q = {8'h03, 8'h03, 8'h00};
    spi_xfer(8);
    check("wr_no_wel_data", 32'(rx_q[2]), 32'h03);

    // Unknown opcode, then WREN + repeated RDSR
    tx_q = {8'h9F, 8'h00, 8'h00};
    spi_xfer(8);
    tx_q = {8'h06};
    spi_xfer(8);
    tx_q = {8'h05, 8'h00, 8'h00};
    spi_xfer(8);
    check("rdsr_wel_b0", 32'(rx_q[1]), 32'h02);
    check("rdsr_wel_b1", 32'(rx_q[2]), 32'h02);

    // Partial data byte must not reach memory
    tx_q = {8'h02, 8'h04, 8'hFF};
    spi_xfer(5);
    tx_q = {8'h03, 8'h04, 8'h00};
    spi_xfer(8);
    check("partial_no_write", 32'(rx_q[2]), 32'h04);
    tx_q = {8'h04};
    spi_xfer(8);

    // Pattern instance: 16 SCLK cycles give 16 MISO transitions
    p0 = pat_edges;
    tx_q = {8'h04, 8'h00};
    spi_xfer(8);
    check("pattern_edges16", 32'(pat_edges - p0), 32'd16);

    // Reset in the middle of a READ
    SPI_CS_n = 1'b0;
    #(HALF);
    v = 8'h03;
    for (int k = 0; k < 20; k++) begin
      if (k == 8) v = 8'h05;
      SPI_MOSI = (k < 16) ? v[7 - (k % 8)] : 1'b0;
      #(HALF);
      SPI_CLK = 1'b1;
      #(HALF);
      SPI_CLK = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge CLKA);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("midrst_miso_pattern", {31'd0, miso_p}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge CLKA);
    #1;
    check("postrst_wait_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("postrst_busy", {31'd0, busy}, 32'd1);
    SPI_CS_n = 1'b1;
    SPI_MOSI = 1'b0;
    #(2 * HALF);
    tx_q = {8'h03, 8'h05, 8'h00};
    spi_xfer(8);
    check("postrst_read", 32'(rx_q[2]), 32'h05);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = 8'h03;
        1: op = 8'h02;
        2: op = 8'h06;
        3: op = 8'h04;
        4: op = 8'h05;
        5: begin
          do op = 8'($urandom_range(0, 255)); while (op >= 8'h02 && op <= 8'h06);
        end
        default: op = 8'h06;
      endcase
      tx_q = {op};
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      spi_xfer(lb);
    end

    // Full memory dump against the model
    tx_q = {8'h03, 8'h00};
    for (int i = 0; i < DEPTH; i++) tx_q.push_back(8'h00);
    spi_xfer(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning memory size in bytes (power of two, 2..256).
REQ-002 The block SHALL have parameter ADDR_BYTES, default 1, meaning address bytes following READ/WRITE opcodes (1..3).
REQ-003 The block SHALL have parameter PATTERN_MODE, default 0, meaning 0 = memory-backed data, 1 = MISO toggles on every SPI_CLK falling edge while selected.
REQ-004 The block SHALL have port CLKA  input  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port SPI_CLK  input  1  SPI mode-0 serial clock, asynchronous to CLKA, at most CLKA/8.
REQ-007 The block SHALL have port SPI_CS_n  input  1  active-low chip select.
REQ-008 The block SHALL have port SPI_MOSI  input  1  serial data in, MSB first.
REQ-009 The block SHALL have port SPI_MISO  output  1  serial data out, MSB first.
REQ-010 The block SHALL have port busy  output  1  high while synchronised SPI_CS_n is low.
REQ-011 The block SHALL have port cmd_err  output  1  one-CLKA-cycle pulse on unknown opcode or on a WRITE rejected because WEL = 0.

Function
REQ-012 SPI_CLK, SPI_CS_n and SPI_MOSI SHALL each pass through a two-flop synchroniser before use; edges are detected on the synchronised signals.
REQ-013 MOSI SHALL be sampled on each synchronised SPI_CLK rising edge; SPI_MISO SHALL update within 3 CLKA cycles of each SPI_CLK falling edge.
REQ-014 The FSM SHALL have states IDLE, CMD, ADDR, RD, WR, IGNORE; a synchronised CS_n falling edge moves IDLE->CMD with the bit counter cleared.
REQ-015 After 8 bits in CMD, the opcode SHALL be decoded: 0x03 READ->ADDR; 0x02 WRITE->ADDR if WEL = 1, else IGNORE plus cmd_err; 0x06 WREN sets WEL->IGNORE; 0x04 WRDI clears WEL->IGNORE; 0x05 RDSR->RD returning the status byte; any other opcode->IGNORE plus cmd_err.
REQ-016 The status byte SHALL be {6'b0, WEL, 1'b0}; RDSR SHALL repeat it for every byte until CS_n rises.
REQ-017 ADDR SHALL shift in 8*ADDR_BYTES bits; the address used is the value modulo DEPTH, upper bits ignored.
REQ-018 In RD, the byte at the current address SHALL be loaded so that its MSB appears on the falling edge following the last address bit; the address increments after each 8 bits and wraps DEPTH-1 -> 0.
REQ-019 In WR, each complete received byte SHALL be written to the current address on the CLKA cycle after its 8th bit is sampled; the address then increments with the same wrap rule.
REQ-020 A partial byte (fewer than 8 bits) at CS_n rise SHALL be discarded without any memory write.
REQ-021 A synchronised CS_n rising edge SHALL return the FSM to IDLE from any state, drive SPI_MISO to 0, and clear WEL if at least one byte was written during that transaction.
REQ-022 In IDLE, CMD, ADDR, WR and IGNORE, SPI_MISO SHALL be 0.
REQ-023 With PATTERN_MODE = 1, opcode decode and memory writes SHALL still occur, but SPI_MISO SHALL invert on every SPI_CLK falling edge while selected and hold its value between transactions.
REQ-024 A CS_n edge and an SPI_CLK edge detected in the same CLKA cycle SHALL be resolved with the CS_n edge taking priority; the SPI_CLK edge is ignored.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously set: FSM IDLE, counters 0, WEL 0, SPI_MISO 0, busy 0, cmd_err 0, synchroniser flops to idle levels (CS_n 1, CLK 0, MOSI 0).
REQ-026 On reset, memory byte i SHALL initialise to i[7:0].
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no further memory write; after release, the block SHALL wait for a fresh CS_n falling edge.

Structure
REQ-028 The opcode constants, the status-bit positions and the FSM state enum SHALL reside in package spi_mem_pkg.
REQ-029 Synchronisation and edge detection SHALL be one sub-module, spi_sync_edge (2-flop synchroniser with rise/fall pulses), instantiated once per input.

Verification
REQ-030 Reset, then READ 0x03 at address 0x05 for 3 bytes -> MISO returns 0x05, 0x06, 0x07.
REQ-031 WREN, then a WRITE to address 0x0E of 0xAA, 0xBB, 0xCC, then READ from 0x0E for 3 bytes -> 0xAA, 0xBB, 0xCC, confirming wrap to address 0; RDSR afterwards returns 0x00.
REQ-032 WRITE without WREN -> cmd_err pulses once and READ at the target address still returns its reset value.
REQ-033 Opcode 0x9F -> cmd_err pulse and MISO held at 0 until CS_n rises; WREN then RDSR -> 0x02.
REQ-034 CS_n raised after 5 data bits of a WRITE byte -> no memory change; rst_n pulsed mid-READ -> busy = 0, MISO = 0, FSM IDLE.
REQ-035 PATTERN_MODE = 1 with 16 SPI_CLK cycles -> MISO shows 16 alternating transitions, one per falling edge.
